skip_subtractor_seq: RTL

- Multi-cycle WIDTH-bit subtractor, D = A - B - bin, computed one SLICE-bit slice per clock, LSB slice first.
- Each slice is a ripple subtract with a borrow-skip bypass: when every bit pair in the slice is equal (A==B bitwise), borrow-out is taken directly from borrow-in through a 2:1 select.
- It is the subtract counterpart of the team's 4-bit carry-skip adder and feeds the ALU datapath through a start/done handshake.

---
 rtl/skip_subtractor_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/skip_subtractor_seq.sv
// skip_subtractor_seq
//   Multi-cycle subtractor D = A - B - bin, one SLICE-bit slice per clock,
//   least-significant slice first. Each slice is a ripple subtract whose
//   borrow-out bypasses the ripple chain through a 2:1 select when every bit
//   pair in the slice is equal. The select only changes timing; the ripple
//   result carries the same value in that case.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, highest priority
//   start    : request, accepted only while busy = 0
//   A, B     : minuend / subtrahend, sampled on the accepting edge
//   bin      : borrow-in, sampled on the accepting edge
//   busy     : operation in progress
//   done     : one-cycle pulse, results valid
//   D        : difference (partially written while busy)
//   bout     : borrow-out (A < B + bin, unsigned)
//   zero     : D == 0
//   ovf      : signed overflow
//   skip_cnt : number of slices whose borrow took the skip path
module skip_subtractor_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [WIDTH-1:0]                     A,
  input  logic [WIDTH-1:0]                     B,
  input  logic                                 bin,
  output logic                                 busy,
  output logic                                 done,
  output logic [WIDTH-1:0]                     D,
  output logic                                 bout,
  output logic                                 zero,
  output logic                                 ovf,
  output logic [$clog2(WIDTH/SLICE+1)-1:0]     skip_cnt
);

  localparam int N   = WIDTH / SLICE;
  localparam int KW  = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic             br_r;
  logic [KW-1:0]    k;

  logic [SLICE-1:0] a_s, b_s, ds;
  logic             br_ripple;
  logic             eq;
  logic             slice_bout;
  logic             last;
  logic [WIDTH-1:0] d_upd;

  assign last = (k == KW'(N - 1));

  // Slice select, ripple subtract, skip mux, and D with the current slice merged.
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (k == KW'(j)) begin
        a_s = a_r[j*SLICE +: SLICE];
        b_s = b_r[j*SLICE +: SLICE];
      end
    end

    br_ripple = br_r;
    eq        = 1'b1;
    ds        = '0;
    for (int unsigned i = 0; i < SLICE; i++) begin
      ds[i]     = a_s[i] ^ b_s[i] ^ br_ripple;
      br_ripple = (~a_s[i] & b_s[i]) | (~(a_s[i] ^ b_s[i]) & br_ripple);
      eq        = eq & ~(a_s[i] ^ b_s[i]);
    end
    slice_bout = eq ? br_r : br_ripple;

    d_upd = D;
    for (int unsigned j = 0; j < N; j++) begin
      if (k == KW'(j)) d_upd[j*SLICE +: SLICE] = ds;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      br_r     <= 1'b0;
      k        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      D        <= '0;
      bout     <= 1'b0;
      zero     <= 1'b0;
      ovf      <= 1'b0;
      skip_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r      <= A;
            b_r      <= B;
            br_r     <= bin;
            D        <= '0;
            skip_cnt <= '0;
            k        <= '0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          D    <= d_upd;
          br_r <= slice_bout;
          if (eq) skip_cnt <= skip_cnt + 1'b1;
          if (last) begin
            // Flags use d_upd so the final slice is included.
            bout <= slice_bout;
            zero <= (d_upd == '0);
            ovf  <= (a_r[MSB] != b_r[MSB]) && (d_upd[MSB] != a_r[MSB]);
            done <= 1'b1;
            busy <= 1'b0;
            k    <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
